axi_rw_arbiter: RTL and testbench
=================================

// Module: axi_rw_arbiter
// PURPOSE
//  Shares the single-port frame-buffer RAM inside the CDC AXI slave between its write-burst
//  engine and its read-burst engine. Grants whole bursts, alternates round-robin under
//  contention and breaks any burst that holds the RAM too long via a watchdog.
//  Sits between the AW/AR address acceptance logic and the RAM port mux, in the ACLK domain.
// PARAMETERS
//  TIMEOUT_CYCLES  1023  max cycles one grant may be held before forced release (1..2^TO_W-1)
//  TO_W            10    width of watchdog counter
//  CNT_W           16    width of per-requester grant counters
//  WR_FIRST        1     1: first contended grant goes to write; 0: to read
// PORTS
//  ACLK            in   1      AXI clock, all logic rising-edge
//  ARESETN         in   1      asynchronous active-low reset
//  wr_req          in   1      write engine holds an accepted AW burst awaiting RAM access (level)
//  wr_done         in   1      pulse: last write beat (WLAST&WVALID&WREADY) this cycle
//  rd_req          in   1      read engine holds an accepted AR burst awaiting RAM access (level)
//  rd_done         in   1      pulse: last read beat (RLAST&RVALID&RREADY) this cycle
//  wr_gnt          out  1      write engine owns RAM port (registered)
//  rd_gnt          out  1      read engine owns RAM port (registered)
//  timeout_err     out  1      one-cycle pulse: watchdog released a grant
//  wr_gnt_cnt      out  CNT_W  number of write grants issued, saturating
//  rd_gnt_cnt      out  CNT_W  number of read grants issued, saturating
// BEHAVIOUR
//  Reset (ARESETN=0, async): state=IDLE, wr_gnt=rd_gnt=0, timeout_err=0, counters=0,
//   watchdog=0, last_gnt = WR_FIRST ? RD : WR. Release is synchronous to ACLK.
//  States: IDLE, WR_OWN, RD_OWN. wr_gnt=(state==WR_OWN), rd_gnt=(state==RD_OWN); never both.
//  IDLE: wr_req&!rd_req -> WR_OWN; rd_req&!wr_req -> RD_OWN; both -> side != last_gnt;
//   neither -> stay. Grant visible the cycle after req is sampled (1-cycle latency).
//  WR_OWN: wr_done -> release; RD_OWN: rd_done -> release. done of non-owner is ignored.
//  Release: next state chosen same cycle as from IDLE using requests sampled that cycle,
//   treating owner's req as 0 (owner must re-arbitrate) -> back-to-back handover with no
//   idle cycle if the other side requests; else IDLE.
//  last_gnt updates on every entry to WR_OWN/RD_OWN; grant counter of that side +1,
//   saturates at 2^CNT_W-1.
//  Watchdog: cleared on every state entry, +1 each cycle in WR_OWN/RD_OWN. When it
//   reaches TIMEOUT_CYCLES-1 without done: release as above, timeout_err=1 for one cycle.
//   done and timeout in same cycle -> normal release, no timeout_err.
//  Requester dropping req while owning does not release; only done/timeout do.
//  Reset mid-burst: grants drop asynchronously; engines are reset by same ARESETN.
// TESTING
//  1 Reset: hold ARESETN=0 100ns, toggle reqs -> gnts=0, counters=0, timeout_err=0.
//  2 Solo write: wr_req=1, wr_done after 8 beats -> wr_gnt 1 cycle after req, drops cycle
//    after done, wr_gnt_cnt=1, rd_gnt never 1.
//  3 Contention: wr_req=rd_req=1 from IDLE, WR_FIRST=1, 4 bursts each -> grants alternate
//    W,R,W,R,... with no idle cycle between; wr_gnt_cnt=rd_gnt_cnt=4.
//  4 Watchdog: TIMEOUT_CYCLES=16, wr_req=1, no wr_done -> wr_gnt high exactly 16 cycles,
//    timeout_err pulses once, rd_req pending then granted next cycle.
//  5 Stray done: in RD_OWN pulse wr_done -> no state change; rd_done+timeout same cycle ->
//    no timeout_err.
//  6 Mid-burst reset + saturation: CNT_W=2, 5 write grants -> wr_gnt_cnt=3; assert ARESETN=0
//    during RD_OWN -> rd_gnt=0 immediately, counters=0.

Source files
------------

// File: rtl/axi_rw_arb_if.sv
// Request/done/grant bundle between the AXI slave's burst engines and the RAM-port arbiter.
// The master side is the pair of burst engines; the slave side is the arbiter.
interface axi_rw_arb_if #(
  parameter int CNT_W = 16
);
  logic             wr_req;
  logic             wr_done;
  logic             rd_req;
  logic             rd_done;
  logic             wr_gnt;
  logic             rd_gnt;
  logic             timeout_err;
  logic [CNT_W-1:0] wr_gnt_cnt;
  logic [CNT_W-1:0] rd_gnt_cnt;

  modport slave (
    input  wr_req, wr_done, rd_req, rd_done,
    output wr_gnt, rd_gnt, timeout_err, wr_gnt_cnt, rd_gnt_cnt
  );

  modport master (
    output wr_req, wr_done, rd_req, rd_done,
    input  wr_gnt, rd_gnt, timeout_err, wr_gnt_cnt, rd_gnt_cnt
  );
endinterface

// File: rtl/axi_rw_arbiter.sv
// Whole-burst round-robin arbiter for the frame-buffer RAM port shared by the write and
// read burst engines, with a watchdog that forcibly releases an over-long grant.
module axi_rw_arbiter #(
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int TO_W           = 10,
  parameter int CNT_W          = 16,
  parameter bit WR_FIRST       = 1'b1
) (
  input  logic         ACLK,
  input  logic         ARESETN,
  axi_rw_arb_if.slave  bus
);

  // One-hot-style encoding so each grant is a direct flop bit.
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    WR_OWN = 2'b01,
    RD_OWN = 2'b10
  } state_e;

  localparam logic [TO_W-1:0] WD_LIMIT = TO_W'(TIMEOUT_CYCLES - 1);

  state_e           state, state_nxt;
  logic             last_wr;
  logic [TO_W-1:0]  wd;
  logic [CNT_W-1:0] wr_cnt, rd_cnt;
  logic             timeout_q;

  logic owner_done, wd_expire, releasing, wr_cand, rd_cand, entering;
  state_e pick;

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic. The owner's own request is masked so it must re-arbitrate.
  // NOTE: every always_comb output gets a default first, so no latch can be inferred.
  always_comb begin
    owner_done = ((state == WR_OWN) && bus.wr_done) || ((state == RD_OWN) && bus.rd_done);
    wd_expire  = (state != IDLE) && (wd == WD_LIMIT);
    releasing  = owner_done || wd_expire;
    wr_cand    = bus.wr_req && (state != WR_OWN);
    rd_cand    = bus.rd_req && (state != RD_OWN);

    if (wr_cand && rd_cand) pick = last_wr ? RD_OWN : WR_OWN;
    else if (wr_cand)       pick = WR_OWN;
    else if (rd_cand)       pick = RD_OWN;
    else                    pick = IDLE;

    state_nxt = state;
    if ((state == IDLE) || releasing) state_nxt = pick;
    entering = (state_nxt != state) && (state_nxt != IDLE);
  end

  // Watchdog, round-robin pointer, grant counters and timeout pulse.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wd        <= '0;
      last_wr   <= !WR_FIRST;
      wr_cnt    <= '0;
      rd_cnt    <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= wd_expire && !owner_done;
      if (state_nxt != state) wd <= '0;
      else if (state != IDLE) wd <= wd + 1'b1;
      if (entering) begin
        last_wr <= (state_nxt == WR_OWN);
        if (state_nxt == WR_OWN && wr_cnt != '1) wr_cnt <= wr_cnt + 1'b1;
        if (state_nxt == RD_OWN && rd_cnt != '1) rd_cnt <= rd_cnt + 1'b1;
      end
    end
  end

  // Output decode.
  always_comb begin
    bus.wr_gnt      = (state == WR_OWN);
    bus.rd_gnt      = (state == RD_OWN);
    bus.timeout_err = timeout_q;
    bus.wr_gnt_cnt  = wr_cnt;
    bus.rd_gnt_cnt  = rd_cnt;
  end

endmodule

// File: tb/tb_axi_rw_arbiter.sv
// Bench for axi_rw_arbiter: two instances (different timeout, counter width and first-grant
// side) checked cycle by cycle against a burst-ownership model plus directed scenario checks.
module tb_axi_rw_arbiter;
  localparam int TO_A = 16;
  localparam int CW_A = 16;
  localparam int TO_B = 5;
  localparam int CW_B = 2;

  logic ACLK    = 1'b0;
  logic ARESETN = 1'b0;
  always #5 ACLK = ~ACLK;

  logic wr_req [2];
  logic wr_done[2];
  logic rd_req [2];
  logic rd_done[2];

  axi_rw_arb_if #(.CNT_W(CW_A)) bus_a ();
  axi_rw_arb_if #(.CNT_W(CW_B)) bus_b ();

  assign bus_a.wr_req  = wr_req[0];
  assign bus_a.wr_done = wr_done[0];
  assign bus_a.rd_req  = rd_req[0];
  assign bus_a.rd_done = rd_done[0];
  assign bus_b.wr_req  = wr_req[1];
  assign bus_b.wr_done = wr_done[1];
  assign bus_b.rd_req  = rd_req[1];
  assign bus_b.rd_done = rd_done[1];

  axi_rw_arbiter #(.TIMEOUT_CYCLES(TO_A), .TO_W(10), .CNT_W(CW_A), .WR_FIRST(1'b1)) dut_a (
    .ACLK(ACLK), .ARESETN(ARESETN), .bus(bus_a));
  axi_rw_arbiter #(.TIMEOUT_CYCLES(TO_B), .TO_W(3), .CNT_W(CW_B), .WR_FIRST(1'b0)) dut_b (
    .ACLK(ACLK), .ARESETN(ARESETN), .bus(bus_b));

  // Observed outputs packed as {wr_gnt, rd_gnt, timeout_err, wr_cnt[15:0], rd_cnt[15:0]}.
  logic [34:0] obs[2];
  assign obs[0] = {bus_a.wr_gnt, bus_a.rd_gnt, bus_a.timeout_err, bus_a.wr_gnt_cnt, bus_a.rd_gnt_cnt};
  assign obs[1] = {bus_b.wr_gnt, bus_b.rd_gnt, bus_b.timeout_err,
                   14'd0, bus_b.wr_gnt_cnt, 14'd0, bus_b.rd_gnt_cnt};

  int total = 0;
  int bad   = 0;

  // Reference model: who owns the RAM (0 none, 1 write, 2 read), how many cycles it has
  // held it, which side won last, and saturating grant tallies.
  int m_own[2], m_held[2], m_wc[2], m_rc[2];
  bit m_lastw[2], m_to[2];

  function automatic int to_lim(int i);
    return (i == 0) ? TO_A : TO_B;
  endfunction

  function automatic int sat_max(int i);
    return (i == 0) ? 65535 : 3;
  endfunction

  always @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int i = 0; i < 2; i++) begin
        m_own[i] = 0; m_held[i] = 0; m_wc[i] = 0; m_rc[i] = 0; m_to[i] = 1'b0;
        m_lastw[i] = (i == 0) ? 1'b0 : 1'b1;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        bit dn, expired, w, r;
        int nxt;
        dn      = (m_own[i] == 1 && wr_done[i]) || (m_own[i] == 2 && rd_done[i]);
        expired = (m_own[i] != 0) && (m_held[i] == to_lim(i));
        m_to[i] = expired && !dn;
        if (m_own[i] == 0 || dn || expired) begin
          w = wr_req[i] && m_own[i] != 1;
          r = rd_req[i] && m_own[i] != 2;
          if (w && r) nxt = m_lastw[i] ? 2 : 1;
          else if (w) nxt = 1;
          else if (r) nxt = 2;
          else        nxt = 0;
          m_own[i]  = nxt;
          m_held[i] = 1;
          if (nxt == 1) begin m_lastw[i] = 1'b1; if (m_wc[i] < sat_max(i)) m_wc[i]++; end
          if (nxt == 2) begin m_lastw[i] = 1'b0; if (m_rc[i] < sat_max(i)) m_rc[i]++; end
        end else begin
          m_held[i]++;
        end
      end
    end
  end

  function automatic logic [34:0] exp_vec(int i);
    logic [15:0] wc, rc;
    wc = m_wc[i][15:0];
    rc = m_rc[i][15:0];
    return {m_own[i] == 1, m_own[i] == 2, m_to[i], wc, rc};
  endfunction

  task automatic cyc();
    @(posedge ACLK);
    @(negedge ACLK);
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < 2; i++) begin
      wr_req[i] = 1'b0; wr_done[i] = 1'b0; rd_req[i] = 1'b0; rd_done[i] = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge ACLK);
    ARESETN = 1'b0;
    clear_inputs();
    #40;
    @(negedge ACLK);
    ARESETN = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge ACLK);
    ARESETN = 1'b0;
    for (int k = 0; k < 10; k++) begin
      for (int i = 0; i < 2; i++) begin
        wr_req[i] = 1'($urandom); rd_req[i] = 1'($urandom);
        wr_done[i] = 1'($urandom); rd_done[i] = 1'($urandom);
      end
      #10;
      for (int i = 0; i < 2; i++) begin
        total++;
        if (obs[i] !== 35'd0) begin
          bad++; $display("FAIL reset_hold[%0d]: got %h want 0", i, obs[i]);
        end
      end
    end
    clear_inputs();
    @(negedge ACLK);
    ARESETN = 1'b1;
    cyc();
    for (int i = 0; i < 2; i++) begin
      total++;
      if (obs[i] !== exp_vec(i)) begin
        bad++; $display("FAIL reset_release[%0d]: got %h want %h", i, obs[i], exp_vec(i));
      end
    end
  endtask

  task automatic test_solo_write();
    bit rd_seen = 1'b0;
    do_reset();
    wr_req[0] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      cyc();
      rd_seen |= bus_a.rd_gnt;
      total++;
      if (bus_a.wr_gnt !== 1'b1 || obs[0] !== exp_vec(0)) begin
        bad++; $display("FAIL solo_beat%0d: got %h want %h", k, obs[0], exp_vec(0));
      end
      if (k == 8) begin wr_done[0] = 1'b1; wr_req[0] = 1'b0; end
    end
    cyc();
    wr_done[0] = 1'b0;
    rd_seen |= bus_a.rd_gnt;
    total++;
    if (bus_a.wr_gnt !== 1'b0 || bus_a.wr_gnt_cnt !== 16'd1 || rd_seen) begin
      bad++; $display("FAIL solo_end: got gnt=%b cnt=%0d rd_seen=%b want 0 1 0",
                      bus_a.wr_gnt, bus_a.wr_gnt_cnt, rd_seen);
    end
  endtask

  task automatic test_contention();
    do_reset();
    wr_req[0] = 1'b1;
    rd_req[0] = 1'b1;
    for (int b = 0; b < 8; b++) begin
      int len;
      logic [1:0] want;
      len  = 1 + int'($urandom_range(3));
      want = (b % 2 == 0) ? 2'b10 : 2'b01;
      for (int l = 1; l <= len; l++) begin
        cyc();
        wr_done[0] = 1'b0; rd_done[0] = 1'b0;
        total++;
        if (obs[0][34:33] !== want || obs[0] !== exp_vec(0)) begin
          bad++; $display("FAIL contend_b%0d_c%0d: got %h want gnt %b model %h",
                          b, l, obs[0], want, exp_vec(0));
        end
        if (l == len) begin
          if (want == 2'b10) wr_done[0] = 1'b1; else rd_done[0] = 1'b1;
          if (b == 7) begin wr_req[0] = 1'b0; rd_req[0] = 1'b0; end
        end
      end
    end
    cyc();
    wr_done[0] = 1'b0; rd_done[0] = 1'b0;
    total++;
    if (bus_a.wr_gnt_cnt !== 16'd4 || bus_a.rd_gnt_cnt !== 16'd4 || obs[0][34:33] !== 2'b00) begin
      bad++; $display("FAIL contend_counts: got w=%0d r=%0d gnt=%b want 4 4 00",
                      bus_a.wr_gnt_cnt, bus_a.rd_gnt_cnt, obs[0][34:33]);
    end
  endtask

  task automatic test_watchdog();
    int wr_cycles = 0;
    int to_pulses = 0;
    bit handover  = 1'b0;
    bit prev_wr   = 1'b0;
    do_reset();
    wr_req[0] = 1'b1;
    for (int n = 0; n < 30; n++) begin
      cyc();
      if (bus_a.wr_gnt) wr_cycles++;
      if (bus_a.timeout_err) to_pulses++;
      if (prev_wr && !bus_a.wr_gnt) handover = bus_a.rd_gnt;
      prev_wr = bus_a.wr_gnt;
      total++;
      if (obs[0] !== exp_vec(0)) begin
        bad++; $display("FAIL watchdog_c%0d: got %h want %h", n, obs[0], exp_vec(0));
      end
      if (n == 0) rd_req[0] = 1'b1;
      if (n == 3) wr_req[0] = 1'b0;
    end
    total++;
    if (wr_cycles != TO_A || to_pulses != 1 || !handover) begin
      bad++; $display("FAIL watchdog_summary: got cycles=%0d pulses=%0d handover=%b want %0d 1 1",
                      wr_cycles, to_pulses, handover, TO_A);
    end
    clear_inputs();
  endtask

  task automatic test_stray_done();
    do_reset();
    rd_req[0] = 1'b1;
    for (int k = 1; k <= TO_A; k++) begin
      cyc();
      wr_done[0] = 1'b0;
      total++;
      if (bus_a.rd_gnt !== 1'b1 || obs[0] !== exp_vec(0)) begin
        bad++; $display("FAIL stray_c%0d: got %h want %h", k, obs[0], exp_vec(0));
      end
      if (k == 4) wr_done[0] = 1'b1;
      if (k == TO_A) begin rd_done[0] = 1'b1; rd_req[0] = 1'b0; end
    end
    cyc();
    rd_done[0] = 1'b0;
    total++;
    if (bus_a.rd_gnt !== 1'b0 || bus_a.timeout_err !== 1'b0 || obs[0] !== exp_vec(0)) begin
      bad++; $display("FAIL stray_done_timeout: got %h want %h", obs[0], exp_vec(0));
    end
  endtask

  task automatic test_saturation_reset();
    int grants = 0;
    int budget = 0;
    do_reset();
    wr_req[1] = 1'b1;
    while (grants < 5 && budget < 40) begin
      cyc();
      budget++;
      wr_done[1] = 1'b0;
      total++;
      if (obs[1] !== exp_vec(1)) begin
        bad++; $display("FAIL sat_c%0d: got %h want %h", budget, obs[1], exp_vec(1));
      end
      if (bus_b.wr_gnt) begin wr_done[1] = 1'b1; grants++; end
    end
    cyc();
    wr_done[1] = 1'b0;
    wr_req[1]  = 1'b0;
    total++;
    if (grants != 5 || bus_b.wr_gnt_cnt !== 2'd3) begin
      bad++; $display("FAIL sat_count: got grants=%0d cnt=%0d want 5 3", grants, bus_b.wr_gnt_cnt);
    end
    rd_req[1] = 1'b1;
    budget = 0;
    do begin cyc(); budget++; end while (!bus_b.rd_gnt && budget < 5);
    total++;
    if (bus_b.rd_gnt !== 1'b1) begin
      bad++; $display("FAIL sat_rd_gnt: got %b want 1", bus_b.rd_gnt);
    end
    #2;
    ARESETN = 1'b0;
    #1;
    total++;
    if (obs[1] !== 35'd0) begin
      bad++; $display("FAIL async_reset: got %h want 0", obs[1]);
    end
    clear_inputs();
    @(negedge ACLK);
    ARESETN = 1'b1;
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 800; n++) begin
      for (int i = 0; i < 2; i++) begin
        wr_req[i]  = ($urandom_range(3) != 0);
        rd_req[i]  = ($urandom_range(3) != 0);
        wr_done[i] = (i == 0) ? ($urandom_range(19) == 0) : ($urandom_range(5) == 0);
        rd_done[i] = (i == 0) ? ($urandom_range(19) == 0) : ($urandom_range(5) == 0);
      end
      cyc();
      for (int i = 0; i < 2; i++) begin
        total++;
        if (obs[i] !== exp_vec(i)) begin
          bad++; $display("FAIL random[%0d]_c%0d: got %h want %h", i, n, obs[i], exp_vec(i));
        end
      end
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_solo_write();
    test_contention();
    test_watchdog();
    test_stray_done();
    test_saturation_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL global_timeout: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
